input_ch_buffer: RTL and testbench

- Per-input-port flit buffer of the symmetric butterfly switch; one instance feeds each lane of the priority allocator's in_ch_hdr_msn / priority_field vectors.
- Queues incoming flits and presents the head flit's most-significant nibble (type[3:2], dest addr[1:0]) to the allocator.
- Pops on the allocator's per-port sel bit and discards flits the allocator never selects.
- Ages waiting headers and raises a priority flag once a header has been refused for AGE_LIMIT cycles, so starved packets get resent ahead of others.

---
 rtl/input_ch_buffer.sv | 143 ++++++++++++++
 tb/tb_input_ch_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/input_ch_buffer.sv
// input_ch_buffer
//   Per-input-port flit buffer for the butterfly switch. It queues incoming
//   flits and presents the head flit's msn (type[3:2], dest[1:0]) to the
//   priority allocator. It pops on the allocator's sel bit and drops flits
//   that can never be granted (null, reserved, orphan payload). Headers that
//   are refused for AGE_LIMIT cycles raise out_priority.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     upstream flit valid
//   in_flit      upstream flit
//   in_ready     buffer can accept a flit (~full, no bypass when full)
//   pop          allocator sel bit for this port
//   out_flit     head flit to crossbar mux (0 when empty)
//   out_msn      head msn to allocator (0 when nothing presentable)
//   out_priority aged-header priority to allocator
//   count        occupancy
//   err_orphan   one-cycle pulse when an orphan payload is dropped
module input_ch_buffer #(
  parameter int FLIT_W    = 8,
  parameter int DEPTH     = 4,
  parameter int AGE_LIMIT = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [FLIT_W-1:0]          in_flit,
  output logic                       in_ready,
  input  logic                       pop,
  output logic [FLIT_W-1:0]          out_flit,
  output logic [3:0]                 out_msn,
  output logic                       out_priority,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_orphan
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(AGE_LIMIT + 1);

  localparam logic [1:0] T_HDR = 2'b11;
  localparam logic [1:0] T_PAY = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_t;

  state_t              state_q, state_d;
  logic [FLIT_W-1:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count_q;
  logic [WW-1:0]       wait_q;

  logic                empty, full, push, do_pop, eval_idle;
  logic [FLIT_W-1:0]   head;
  logic [1:0]          head_type;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign head      = mem[rd_ptr];
  assign head_type = head[FLIT_W-1:FLIT_W-2];
  assign push      = in_valid & ~full;
  assign in_ready  = ~full;
  assign count     = count_q;

  // A non-payload head in XFER ends the packet; it is judged with the IDLE
  // rules in the same cycle so no bubble is inserted between packets.
  assign eval_idle = (state_q == S_IDLE) |
                     ((state_q == S_XFER) & ~empty & (head_type != T_PAY));

  // Flit storage: data only, never reset; unwritten entries are masked by
  // count on the outputs.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  // State register, pointers, occupancy and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Saturating age of a refused header; cleared on grant or outside WAIT.
      if ((state_q == S_WAIT) && !do_pop) begin
        if (wait_q != WW'(AGE_LIMIT)) wait_q <= wait_q + 1'b1;
      end else begin
        wait_q <= '0;
      end
    end
  end

  // Next-state and pop decision
  always_comb begin
    state_d = state_q;
    do_pop  = 1'b0;
    if (!empty) begin
      if (eval_idle) begin
        if (head_type == T_HDR) begin
          state_d = S_WAIT;
        end else begin
          // null, reserved and orphan payloads are dropped one per cycle
          do_pop  = 1'b1;
          state_d = S_IDLE;
        end
      end else if (state_q == S_WAIT) begin
        if (pop) begin
          do_pop  = 1'b1;
          state_d = S_XFER;
        end
      end else begin
        // XFER with a payload at the head
        do_pop = pop;
      end
    end
  end

  // Outputs
  always_comb begin
    out_msn    = 4'b0000;
    err_orphan = 1'b0;
    if (!empty) begin
      if (eval_idle) begin
        if (head_type == T_HDR)      out_msn    = head[FLIT_W-1:FLIT_W-4];
        else if (head_type == T_PAY) err_orphan = 1'b1;
      end else begin
        out_msn = head[FLIT_W-1:FLIT_W-4];
      end
    end
    out_flit     = empty ? '0 : head;
    out_priority = (state_q == S_WAIT) && (wait_q == WW'(AGE_LIMIT));
  end

endmodule

// File: tb/tb_input_ch_buffer.sv
module tb_input_ch_buffer;

  localparam int FLIT_W    = 8;
  localparam int DEPTH     = 4;
  localparam int AGE_LIMIT = 6;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic [FLIT_W-1:0]      in_flit = '0;
  logic                   in_ready;
  logic                   pop = 1'b0;
  logic [FLIT_W-1:0]      out_flit;
  logic [3:0]             out_msn;
  logic                   out_priority;
  logic [$clog2(DEPTH):0] count;
  logic                   err_orphan;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of flits, the packet phase and the header age.
  logic [7:0] q[$];
  int         mode = 0;   // 0 idle, 1 header waiting for grant, 2 in packet
  int         age  = 0;

  input_ch_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit(in_flit),
    .in_ready(in_ready), .pop(pop), .out_flit(out_flit), .out_msn(out_msn),
    .out_priority(out_priority), .count(count), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance.
  task automatic step(input logic v, input logic [7:0] f, input logic p);
    logic [7:0] hd;
    logic [1:0] ty;
    logic [3:0] emsn;
    logic       eorph, epop, was_full;
    int         eff, nmode;
    in_valid = v; in_flit = f; pop = p;
    #1;
    emsn = 4'h0; eorph = 1'b0; epop = 1'b0; nmode = mode;
    hd = (q.size() > 0) ? q[0] : 8'h00;
    ty = hd[7:6];
    eff = mode;
    if (mode == 2 && q.size() > 0 && ty != 2'b10) eff = 0;
    if (q.size() > 0) begin
      case (eff)
        0: begin
          if (ty == 2'b11) begin emsn = hd[7:4]; nmode = 1; end
          else begin epop = 1'b1; nmode = 0; eorph = (ty == 2'b10); end
        end
        1: begin
          emsn = hd[7:4];
          if (p) begin epop = 1'b1; nmode = 2; end
        end
        default: begin emsn = hd[7:4]; epop = p; end
      endcase
    end
    chk("out_msn",      out_msn,      emsn);
    chk("err_orphan",   err_orphan,   eorph);
    chk("out_flit",     out_flit,     hd);
    chk("out_priority", out_priority, (mode == 1 && age == AGE_LIMIT));
    chk("count",        count,        q.size());
    chk("in_ready",     in_ready,     q.size() < DEPTH);
    was_full = (q.size() == DEPTH);
    @(posedge clk); #1;
    if (epop) void'(q.pop_front());
    if (v && !was_full) q.push_back(f);
    if (mode == 1 && !epop) age = (age < AGE_LIMIT) ? age + 1 : AGE_LIMIT;
    else age = 0;
    mode = nmode;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    in_valid = 1'b0; pop = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready,     1'b1);
    chk("rst_msn",      out_msn,      4'h0);
    chk("rst_flit",     out_flit,     8'h00);
    chk("rst_prio",     out_priority, 1'b0);
    chk("rst_count",    count,        0);
    chk("rst_orphan",   err_orphan,   1'b0);
    q.delete(); mode = 0; age = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rand_flit();
    int r;
    logic [1:0] ty;
    r = $urandom_range(0, 99);
    if (r < 30)      ty = 2'b11;
    else if (r < 75) ty = 2'b10;
    else if (r < 90) ty = 2'b00;
    else             ty = 2'b01;
    return {ty, 6'($urandom_range(0, 63))};
  endfunction

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Header into empty buffer appears next cycle
    step(1'b1, 8'hC5, 1'b0);
    chk("t1_msn_C",   out_msn, 4'hC);
    chk("t1_count_1", count,   1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Ageing of a refused header
    do_reset();
    step(1'b1, 8'hC0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0);
    chk("t2_prio_hi", out_priority, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_prio_lo", out_priority, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Packet followed by next header, pop held high
    do_reset();
    step(1'b1, 8'hC1, 1'b1);
    step(1'b1, 8'hA1, 1'b1);
    step(1'b1, 8'hA2, 1'b1);
    step(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Full buffer: no bypass
    do_reset();
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'hC4, 1'b0);
    chk("t4_count_4", count,    4);
    chk("t4_not_rdy", in_ready, 1'b0);
    step(1'b1, 8'hC5, 1'b0);
    step(1'b1, 8'hC6, 1'b1);
    chk("t4_count_3", count, 3);
    step(1'b0, 8'h00, 1'b0);

    // Null then orphan payload dropped
    do_reset();
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'hA7, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Reset in the middle of a packet with three flits stored
    do_reset();
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b1);
    step(1'b1, 8'hA3, 1'b0);
    chk("t6_count_3", count, 3);
    do_reset();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 99) < 60, rand_flit(), $urandom_range(0, 99) < 55);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
